// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: fetch FSM states, halt causes and basic widths.
package core_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;

  localparam logic [1:0] HALT_NONE     = 2'b00;
  localparam logic [1:0] HALT_MISALIGN = 2'b01;
  localparam logic [1:0] HALT_REQ      = 2'b10;

  localparam logic [XLEN-1:0] INST_ILLEGAL = '0;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load captures a fetch, flush kills valid only, else hold.
module ifid_reg
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            illegal_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] inst_o,
  output logic            illegal_o
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      pc_o      <= '0;
      pc4_o     <= '0;
      inst_o    <= '0;
      illegal_o <= 1'b0;
    end else if (flush) begin
      valid_o <= 1'b0;
    end else if (load) begin
      valid_o   <= 1'b1;
      pc_o      <= pc_i;
      pc4_o     <= pc_i + XLEN'(4);
      inst_o    <= inst_i;
      illegal_o <= illegal_i;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC ownership, IF/ID capture, redirect/flush, halt FSM.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0008,
  parameter int unsigned IMEM_BYTES = 512,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_target_i,
  input  logic             halt_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_inst_i,
  output logic             ifid_valid_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_pc4_o,
  output logic [31:0]      ifid_inst_o,
  output logic             ifid_illegal_o,
  output logic             halted_o,
  output logic [1:0]       halt_cause_o,
  output logic [31:0]      halt_pc_o,
  output logic [CNT_W-1:0] fetch_count_o
);
  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic             r_halted;
  logic [1:0]       r_cause;
  logic [31:0]      r_halt_pc;
  logic [CNT_W-1:0] r_count;

  logic w_misalign;
  logic w_run;
  logic w_load;
  logic w_flush;
  logic w_illegal;

  assign w_run      = (r_state == RUN);
  assign w_misalign = redirect_valid_i && (redirect_target_i[1:0] != 2'b00);
  assign w_load     = w_run && !redirect_valid_i && !halt_i && !stall_i;
  // HALT keeps flushing so valid stays low while the captured fields stay frozen.
  assign w_flush    = (w_run && (redirect_valid_i || halt_i)) || (r_state == HALT);
  assign w_illegal  = (imem_inst_i == INST_ILLEGAL) || (r_pc >= 32'(IMEM_BYTES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_halted  <= 1'b0;
      r_cause   <= HALT_NONE;
      r_halt_pc <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (w_misalign) begin
            r_state   <= HALT;
            r_halted  <= 1'b1;
            r_cause   <= HALT_MISALIGN;
            r_halt_pc <= redirect_target_i;
          end else if (redirect_valid_i) begin
            r_pc <= redirect_target_i;
          end else if (halt_i) begin
            r_state   <= HALT;
            r_halted  <= 1'b1;
            r_cause   <= HALT_REQ;
            r_halt_pc <= r_pc;
          end else if (!stall_i) begin
            r_pc <= r_pc + 32'd4;
            if (r_count != '1) r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .flush     (w_flush),
    .pc_i      (r_pc),
    .inst_i    (imem_inst_i),
    .illegal_i (w_illegal),
    .valid_o   (ifid_valid_o),
    .pc_o      (ifid_pc_o),
    .pc4_o     (ifid_pc4_o),
    .inst_o    (ifid_inst_o),
    .illegal_o (ifid_illegal_o)
  );

  assign imem_addr_o   = r_pc;
  assign halted_o      = r_halted;
  assign halt_cause_o  = r_cause;
  assign halt_pc_o     = r_halt_pc;
  assign fetch_count_o = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default instance plus a CNT_W=3 instance for saturation.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, rv, halt;
  logic [31:0] tgt;

  logic [31:0] addr, inst, ipc, ipc4, iinst, hpc;
  logic        ival, iill, hlt;
  logic [1:0]  cause;
  logic [31:0] cnt;

  logic [31:0] addr3, inst3, ipc3, ipc43, iinst3, hpc3;
  logic        ival3, iill3, hlt3;
  logic [1:0]  cause3;
  logic [2:0]  cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory contents: nonzero everywhere except address 0x24.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h24) ? 32'h0 : (a ^ 32'hA5A5_0013);
  endfunction

  assign inst  = mem(addr);
  assign inst3 = mem(addr3);

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_target_i(tgt), .halt_i(halt), .imem_addr_o(addr), .imem_inst_i(inst),
    .ifid_valid_o(ival), .ifid_pc_o(ipc), .ifid_pc4_o(ipc4), .ifid_inst_o(iinst),
    .ifid_illegal_o(iill), .halted_o(hlt), .halt_cause_o(cause), .halt_pc_o(hpc),
    .fetch_count_o(cnt)
  );

  fetch_stage #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_target_i(tgt), .halt_i(halt), .imem_addr_o(addr3), .imem_inst_i(inst3),
    .ifid_valid_o(ival3), .ifid_pc_o(ipc3), .ifid_pc4_o(ipc43), .ifid_inst_o(iinst3),
    .ifid_illegal_o(iill3), .halted_o(hlt3), .halt_cause_o(cause3), .halt_pc_o(hpc3),
    .fetch_count_o(cnt3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_boot();
    rst_n = 1'b0; stall = 0; rv = 0; halt = 0; tgt = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; rv = 0; halt = 0; tgt = '0;
    step();
    n_cmp++; if (addr !== 32'h8) begin n_bad++; $display("FAIL rst_addr got=%h exp=%h", addr, 32'h8); end
    n_cmp++; if (ival !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", ival); end
    n_cmp++; if (ipc !== 32'h0 || ipc4 !== 32'h0 || iinst !== 32'h0 || iill !== 1'b0) begin
      n_bad++; $display("FAIL rst_ifid got=%h/%h/%h/%b exp=0", ipc, ipc4, iinst, iill); end
    n_cmp++; if (hlt !== 1'b0 || cause !== 2'b00 || hpc !== 32'h0) begin
      n_bad++; $display("FAIL rst_halt got=%b/%b/%h exp=0", hlt, cause, hpc); end
    n_cmp++; if (cnt !== 32'h0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", cnt); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    reset_and_boot();
    n_cmp++; if (ival !== 1'b0 || addr !== 32'h8) begin
      n_bad++; $display("FAIL boot got valid=%b addr=%h exp 0/8", ival, addr); end
    for (int unsigned i = 0; i < 4; i++) begin
      exp_pc = 32'h8 + 32'(4 * i);
      step();
      n_cmp++; if (ival !== 1'b1 || ipc !== exp_pc || ipc4 !== exp_pc + 4 || iinst !== mem(exp_pc) || iill !== 1'b0) begin
        n_bad++; $display("FAIL run_%0d got v=%b pc=%h pc4=%h inst=%h ill=%b exp pc=%h", i, ival, ipc, ipc4, iinst, iill, exp_pc); end
    end
    n_cmp++; if (cnt !== 32'd4) begin n_bad++; $display("FAIL run_count got=%0d exp=4", cnt); end
  endtask

  task automatic test_stall();
    reset_and_boot();
    step(); step();
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (ipc !== 32'hC || iinst !== mem(32'hC) || ival !== 1'b1 || addr !== 32'h10 || cnt !== 32'd2) begin
        n_bad++; $display("FAIL stall_%0d got pc=%h inst=%h v=%b addr=%h cnt=%0d exp C/-/1/10/2", i, ipc, iinst, ival, addr, cnt); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (ipc !== 32'h10 || addr !== 32'h14 || cnt !== 32'd3) begin
      n_bad++; $display("FAIL stall_resume got pc=%h addr=%h cnt=%0d exp 10/14/3", ipc, addr, cnt); end
  endtask

  task automatic test_redirect();
    // Continues from test_stall: IF/ID=0x10, pc_q=0x14.
    rv = 1'b1; tgt = 32'h14; stall = 1'b1;
    step();
    rv = 1'b0; stall = 1'b0;
    n_cmp++; if (addr !== 32'h14 || ival !== 1'b0 || cnt !== 32'd3) begin
      n_bad++; $display("FAIL redir_flush got addr=%h v=%b cnt=%0d exp 14/0/3", addr, ival, cnt); end
    step();
    n_cmp++; if (ipc !== 32'h14 || ival !== 1'b1 || addr !== 32'h18 || cnt !== 32'd4) begin
      n_bad++; $display("FAIL redir_fetch got pc=%h v=%b addr=%h cnt=%0d exp 14/1/18/4", ipc, ival, addr, cnt); end
  endtask

  task automatic test_misalign();
    rv = 1'b1; tgt = 32'h16;
    step();
    n_cmp++; if (hlt !== 1'b1 || cause !== 2'b01 || hpc !== 32'h16 || addr !== 32'h18 || ival !== 1'b0) begin
      n_bad++; $display("FAIL mis_halt got h=%b c=%b hpc=%h addr=%h v=%b exp 1/01/16/18/0", hlt, cause, hpc, addr, ival); end
    tgt = 32'h40; halt = 1'b1;
    step();
    rv = 1'b0; halt = 1'b0;
    step();
    n_cmp++; if (hlt !== 1'b1 || cause !== 2'b01 || hpc !== 32'h16 || addr !== 32'h18 || ival !== 1'b0 || ipc !== 32'h14) begin
      n_bad++; $display("FAIL mis_frozen got h=%b c=%b hpc=%h addr=%h v=%b pc=%h", hlt, cause, hpc, addr, ival, ipc); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (addr !== 32'h8 || hlt !== 1'b0 || cause !== 2'b00 || hpc !== 32'h0 || cnt !== 32'h0) begin
      n_bad++; $display("FAIL mis_reset got addr=%h h=%b c=%b hpc=%h cnt=%0d", addr, hlt, cause, hpc, cnt); end
    step();
    n_cmp++; if (ival !== 1'b0) begin n_bad++; $display("FAIL mis_boot got v=%b exp 0", ival); end
    step();
    n_cmp++; if (ival !== 1'b1 || ipc !== 32'h8) begin
      n_bad++; $display("FAIL mis_rerun got v=%b pc=%h exp 1/8", ival, ipc); end
  endtask

  task automatic test_illegal_and_halt();
    reset_and_boot();
    rv = 1'b1; tgt = 32'h24;
    step();
    rv = 1'b0;
    step();
    n_cmp++; if (ipc !== 32'h24 || iinst !== 32'h0 || iill !== 1'b1 || ival !== 1'b1 || hlt !== 1'b0) begin
      n_bad++; $display("FAIL ill_zero got pc=%h inst=%h ill=%b v=%b h=%b", ipc, iinst, iill, ival, hlt); end
    step();
    n_cmp++; if (ipc !== 32'h28 || iill !== 1'b0) begin
      n_bad++; $display("FAIL ill_clear got pc=%h ill=%b exp 28/0", ipc, iill); end
    rv = 1'b1; tgt = 32'h1FC;
    step();
    rv = 1'b0;
    step();
    n_cmp++; if (ipc !== 32'h1FC || iill !== 1'b0) begin
      n_bad++; $display("FAIL ill_lastword got pc=%h ill=%b exp 1fc/0", ipc, iill); end
    step();
    n_cmp++; if (ipc !== 32'h200 || iill !== 1'b1 || ival !== 1'b1 || hlt !== 1'b0) begin
      n_bad++; $display("FAIL ill_range got pc=%h ill=%b v=%b h=%b exp 200/1/1/0", ipc, iill, ival, hlt); end
    halt = 1'b1;
    step();
    halt = 1'b0;
    n_cmp++; if (hlt !== 1'b1 || cause !== 2'b10 || hpc !== 32'h204 || ival !== 1'b0 || addr !== 32'h204) begin
      n_bad++; $display("FAIL halt_req got h=%b c=%b hpc=%h v=%b addr=%h exp 1/10/204/0/204", hlt, cause, hpc, ival, addr); end
  endtask

  task automatic test_wrap();
    reset_and_boot();
    rv = 1'b1; tgt = 32'hFFFF_FFFC;
    step();
    rv = 1'b0;
    step();
    n_cmp++; if (ipc !== 32'hFFFF_FFFC || ipc4 !== 32'h0 || iill !== 1'b1 || addr !== 32'h0 || hlt !== 1'b0) begin
      n_bad++; $display("FAIL wrap got pc=%h pc4=%h ill=%b addr=%h h=%b", ipc, ipc4, iill, addr, hlt); end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_c;
    reset_and_boot();
    for (int unsigned i = 1; i <= 10; i++) begin
      step();
      exp_c = (i > 7) ? 3'd7 : 3'(i);
      n_cmp++; if (cnt3 !== exp_c || ival3 !== 1'b1) begin
        n_bad++; $display("FAIL sat_%0d got cnt=%0d v=%b exp %0d/1", i, cnt3, ival3, exp_c); end
    end
    n_cmp++; if (cnt !== 32'd10) begin n_bad++; $display("FAIL sat_wide got=%0d exp=10", cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_misalign();
    test_illegal_and_halt();
    test_wrap();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
